// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : delay_line_ctrl
// Description: Run-time programmable delay line with fill/flush controller.
//              A circular buffer is written every cycle; the read side taps it
//              at (wr_ptr - D) and the output is blanked until the buffer holds
//              D words written under the current delay setting.
//              Optional macro DELAY_LINE_VSYNC_LOAD_EN defers accepted delay
//              loads to the next rising edge of i_vsync.
// Revision   : 1.0 - initial release
// ============================================================================
module delay_line_ctrl #(
  parameter int p_width      = 24,
  parameter int p_max_delay  = 64,
  parameter int p_delay_bits = 7,
  parameter int p_init_delay = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [p_width-1:0]      i_data,
  input  logic [p_delay_bits-1:0] i_cfg_delay,
  input  logic                    i_cfg_load,
  input  logic                    i_vsync,
  output logic [p_width-1:0]      o_data,
  output logic                    o_valid,
  output logic                    o_busy,
  output logic                    o_cfg_err,
  output logic [p_delay_bits-1:0] o_delay_cur
);

  localparam int c_aw = (p_max_delay > 1) ? $clog2(p_max_delay) : 1;
  // One extra bit so wr_ptr + depth - D never wraps for any legal D.
  localparam int c_ew = p_delay_bits + 1;

  localparam logic [c_aw-1:0]         c_ptr_last = c_aw'(p_max_delay - 1);
  localparam logic [p_delay_bits-1:0] c_max_d    = p_delay_bits'(p_max_delay);
  localparam logic [p_delay_bits-1:0] c_init_d   = p_delay_bits'(p_init_delay);
  localparam logic [c_ew-1:0]         c_depth_w  = c_ew'(p_max_delay);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  logic [p_width-1:0]      mem_q [p_max_delay];
  logic [c_aw-1:0]         wr_ptr_q;
  logic [c_aw-1:0]         wr_ptr_d;
  logic [c_ew-1:0]         rd_sum_d;
  logic [c_aw-1:0]         rd_addr_d;
  state_t                  state_q;
  logic [p_delay_bits-1:0] fill_cnt_q;
  logic [p_delay_bits-1:0] fill_inc_d;
  logic [p_delay_bits-1:0] delay_cur_q;
  logic                    valid_q;
  logic                    cfg_err_q;
  logic                    cfg_ok_d;
  logic                    load_ok_d;
  logic                    fill_done_d;

`ifdef DELAY_LINE_VSYNC_LOAD_EN
  logic [p_delay_bits-1:0] pend_q;
  logic [p_delay_bits-1:0] pend_d;
  logic                    vsync_q;
  logic                    vsync_rise_d;
`else
  // Frame sync has no role when loads apply immediately.
  logic                    unused_vsync;
  assign unused_vsync = i_vsync;
`endif

  // Write pointer advance with wrap at the last buffer slot.
  always_comb begin
    wr_ptr_d = (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + 1'b1;
  end

  // Read tap at (wr_ptr - D) mod depth; D == depth lands on the slot about to be overwritten.
  always_comb begin
    rd_sum_d = c_ew'(wr_ptr_q) + c_depth_w - c_ew'(delay_cur_q);
    if (rd_sum_d >= c_depth_w) begin
      rd_sum_d = rd_sum_d - c_depth_w;
    end
    rd_addr_d = c_aw'(rd_sum_d);
  end

  // Load validation and fill progress decode.
  always_comb begin
    cfg_ok_d    = (i_cfg_delay != '0) && (i_cfg_delay <= c_max_d);
    load_ok_d   = i_cfg_load && cfg_ok_d;
    fill_inc_d  = fill_cnt_q + 1'b1;
    fill_done_d = (fill_inc_d == delay_cur_q);
  end

  // Buffer storage: written every cycle, never reset.
  always_ff @(posedge i_clk) begin
    mem_q[wr_ptr_q] <= i_data;
  end

  // Write pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

`ifdef DELAY_LINE_VSYNC_LOAD_EN
  // A load arriving on the same cycle as the sync edge wins over the older pending value.
  always_comb begin
    vsync_rise_d = i_vsync && !vsync_q;
    pend_d       = load_ok_d ? i_cfg_delay : pend_q;
  end

  // Frame sync edge detector.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= i_vsync;
    end
  end
`endif

  // Controller FSM with registered valid/error outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      delay_cur_q <= c_init_d;
      valid_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef DELAY_LINE_VSYNC_LOAD_EN
      pend_q      <= '0;
`endif
    end else begin
      cfg_err_q <= i_cfg_load && !cfg_ok_d;
`ifdef DELAY_LINE_VSYNC_LOAD_EN
      if ((state_q == ST_PEND) && vsync_rise_d) begin
        delay_cur_q <= pend_d;
        fill_cnt_q  <= '0;
        state_q     <= ST_FILL;
        valid_q     <= 1'b0;
      end else begin
        if (load_ok_d) begin
          pend_q  <= i_cfg_delay;
          state_q <= ST_PEND;
        end
        // A fill interrupted by a pending load still completes under the old delay.
        if (!valid_q) begin
          fill_cnt_q <= fill_inc_d;
          if (fill_done_d) begin
            valid_q <= 1'b1;
            if ((state_q == ST_FILL) && !load_ok_d) begin
              state_q <= ST_RUN;
            end
          end
        end
      end
`else
      if (load_ok_d) begin
        delay_cur_q <= i_cfg_delay;
        fill_cnt_q  <= '0;
        state_q     <= ST_FILL;
        valid_q     <= 1'b0;
      end else if (state_q == ST_FILL) begin
        fill_cnt_q <= fill_inc_d;
        if (fill_done_d) begin
          state_q <= ST_RUN;
          valid_q <= 1'b1;
        end
      end
`endif
    end
  end

  assign o_data      = valid_q ? mem_q[rd_addr_d] : '0;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q != ST_RUN);
  assign o_cfg_err   = cfg_err_q;
  assign o_delay_cur = delay_cur_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_delay_line_ctrl
// Description: Directed bench for delay_line_ctrl. Input data is the cycle
//              index plus one, so the expected delayed word is cycle+1-D.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_delay_line_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic [23:0] i_data;
  logic [6:0]  i_cfg_delay;
  logic        i_cfg_load;
  logic        i_vsync;
  logic [23:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_cfg_err;
  logic [6:0]  o_delay_cur;

  int cyc;
  int checks;
  int errors;

  typedef struct packed {
    logic        load;
    logic [6:0]  cfg;
    logic        ev;
    logic [23:0] ed;
    logic        eerr;
    logic [6:0]  edc;
    logic        ebusy;
  } vec_t;

  vec_t tbl [22];

  delay_line_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_cfg_delay (i_cfg_delay),
    .i_cfg_load  (i_cfg_load),
    .i_vsync     (i_vsync),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_cfg_err   (o_cfg_err),
    .o_delay_cur (o_delay_cur)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic l, input int c, input logic v, input int d,
                              input logic e, input int dc, input logic b);
    vec_t r;
    r.load  = l;
    r.cfg   = 7'(c);
    r.ev    = v;
    r.ed    = 24'(d);
    r.eerr  = e;
    r.edc   = 7'(dc);
    r.ebusy = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; inputs for the new cycle are set 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    i_data     = 24'(cyc + 1);
    i_cfg_load = 1'b0;
  endtask

  task automatic do_reset_release();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 1);
    chk("rst_err", o_cfg_err, 0);
    chk("rst_dcur", o_delay_cur, 5);
    i_rst_n    = 1'b1;
    cyc        = 0;
    i_data     = 24'd1;
    i_cfg_load = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    i_rst_n     = 1'b0;
    i_data      = '0;
    i_cfg_delay = '0;
    i_cfg_load  = 1'b0;
    i_vsync     = 1'b0;

    do_reset_release();

`ifndef DELAY_LINE_VSYNC_LOAD_EN
    //            load cfg  valid data err dcur busy
    tbl[0]  = mk(0,  0,  0,  0, 0, 5, 1);
    tbl[1]  = mk(0,  0,  0,  0, 0, 5, 1);
    tbl[2]  = mk(0,  0,  0,  0, 0, 5, 1);
    tbl[3]  = mk(0,  0,  0,  0, 0, 5, 1);
    tbl[4]  = mk(0,  0,  0,  0, 0, 5, 1);
    tbl[5]  = mk(0,  0,  1,  1, 0, 5, 0);
    tbl[6]  = mk(1,  1,  1,  2, 0, 5, 0);
    tbl[7]  = mk(0,  0,  0,  0, 0, 1, 1);
    tbl[8]  = mk(0,  0,  1,  8, 0, 1, 0);
    tbl[9]  = mk(1,  0,  1,  9, 0, 1, 0);
    tbl[10] = mk(1, 65,  1, 10, 1, 1, 0);
    tbl[11] = mk(1,  3,  1, 11, 1, 1, 0);
    tbl[12] = mk(0,  0,  0,  0, 0, 3, 1);
    tbl[13] = mk(0,  0,  0,  0, 0, 3, 1);
    tbl[14] = mk(0,  0,  0,  0, 0, 3, 1);
    tbl[15] = mk(0,  0,  1, 13, 0, 3, 0);
    tbl[16] = mk(1,  3,  1, 14, 0, 3, 0);
    tbl[17] = mk(0,  0,  0,  0, 0, 3, 1);
    tbl[18] = mk(0,  0,  0,  0, 0, 3, 1);
    tbl[19] = mk(0,  0,  0,  0, 0, 3, 1);
    tbl[20] = mk(0,  0,  1, 18, 0, 3, 0);
    tbl[21] = mk(0,  0,  1, 19, 0, 3, 0);

    for (int i = 0; i < 22; i++) begin
      i_cfg_load  = tbl[i].load;
      i_cfg_delay = tbl[i].cfg;
      chk("tbl_valid", o_valid, tbl[i].ev);
      chk("tbl_data", o_data, tbl[i].ed);
      chk("tbl_err", o_cfg_err, tbl[i].eerr);
      chk("tbl_dcur", o_delay_cur, tbl[i].edc);
      chk("tbl_busy", o_busy, tbl[i].ebusy);
      tick();
    end

    // Maximum delay: 64 blank cycles, then read-before-write latency of 64.
    i_cfg_load  = 1'b1;
    i_cfg_delay = 7'd64;
    tick();
    for (int k = 0; k < 64; k++) begin
      chk("d64_fill_valid", o_valid, 0);
      chk("d64_fill_data", o_data, 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk("d64_valid", o_valid, 1);
      chk("d64_data", o_data, 32'(cyc + 1 - 64));
      chk("d64_busy", o_busy, 0);
      tick();
    end

    // Out-of-range loads are rejected without disturbing the running output.
    i_cfg_load  = 1'b1;
    i_cfg_delay = 7'd0;
    tick();
    chk("rej0_err", o_cfg_err, 1);
    chk("rej0_dcur", o_delay_cur, 64);
    chk("rej0_valid", o_valid, 1);
    i_cfg_load  = 1'b1;
    i_cfg_delay = 7'd65;
    tick();
    chk("rej65_err", o_cfg_err, 1);
    chk("rej65_dcur", o_delay_cur, 64);
    chk("rej65_valid", o_valid, 1);
    chk("rej65_data", o_data, 32'(cyc + 1 - 64));
    tick();
    chk("rej_err_clear", o_cfg_err, 0);
    chk("rej_valid_kept", o_valid, 1);

    // Load 10, then load 3 on the 4th fill cycle: fill restarts with 3.
    i_cfg_load  = 1'b1;
    i_cfg_delay = 7'd10;
    tick();
    tick();
    tick();
    tick();
    chk("rst_fill_dcur10", o_delay_cur, 10);
    chk("rst_fill_valid", o_valid, 0);
    i_cfg_load  = 1'b1;
    i_cfg_delay = 7'd3;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("refill_valid", o_valid, 0);
      chk("refill_dcur", o_delay_cur, 3);
      tick();
    end
    chk("refill_up", o_valid, 1);
    chk("refill_data", o_data, 32'(cyc + 1 - 3));
    tick();
    chk("refill_data2", o_data, 32'(cyc + 1 - 3));
`else
    // Deferred load: delay unchanged until the sync edge, then an 8-cycle fill.
    for (int k = 0; k < 10; k++) tick();
    chk("pre_valid", o_valid, 1);
    chk("pre_data", o_data, 32'(cyc + 1 - 5));
    i_cfg_load  = 1'b1;
    i_cfg_delay = 7'd8;
    tick();
    for (int k = 0; k < 99; k++) begin
      chk("pend_dcur", o_delay_cur, 5);
      chk("pend_busy", o_busy, 1);
      chk("pend_valid", o_valid, 1);
      chk("pend_data", o_data, 32'(cyc + 1 - 5));
      tick();
    end
    i_vsync = 1'b1;
    chk("vs_dcur", o_delay_cur, 5);
    chk("vs_busy", o_busy, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("vs_fill_valid", o_valid, 0);
      chk("vs_fill_dcur", o_delay_cur, 8);
      chk("vs_fill_busy", o_busy, 1);
      tick();
    end
    chk("vs_run_valid", o_valid, 1);
    chk("vs_run_busy", o_busy, 0);
    chk("vs_run_data", o_data, 32'(cyc + 1 - 8));
    i_vsync = 1'b0;
    tick();
    chk("vs_run_data2", o_data, 32'(cyc + 1 - 8));
`endif

    // Asynchronous reset in the middle of RUN clears outputs before the next edge.
    tick();
    chk("pre_arst_valid", o_valid, 1);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("arst_data", o_data, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 1);
    chk("arst_dcur", o_delay_cur, 5);
    @(posedge i_clk);
    #1;
    i_rst_n    = 1'b1;
    cyc        = 0;
    i_data     = 24'd1;
    i_cfg_load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("post_arst_valid", o_valid, 0);
      tick();
    end
    chk("post_arst_up", o_valid, 1);
    chk("post_arst_data", o_data, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
